// File: rtl/fft_resp_pkg.sv
// rtl/fft_resp_pkg.sv - shared types, default widths and address decode for the FFT result responder
package fft_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCEPT = 2'd2
    } resp_state_e;

    localparam int DEF_ADDRESSWIDTH = 32;
    localparam int DEF_DATAWIDTH    = 32;
    localparam int DEF_IDX_W        = 9;
    localparam int WCNT_W           = 4;

    // Word index relative to the buffer base; caller slices the low bits it needs.
    function automatic logic [63:0] addr_word_index(input logic [63:0] addr, input logic [63:0] base);
        return (addr - base) >> 2;
    endfunction

    // A byte address hits the buffer iff base <= addr < base + 4 * 2**idx_w.
    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                           input int unsigned idx_w);
        logic [63:0] word_idx;
        word_idx = (addr - base) >> 2;
        return (addr >= base) && ((word_idx >> idx_w) == 64'd0);
    endfunction

endpackage

// File: rtl/fft_resp_if.sv
// rtl/fft_resp_if.sv - Avalon-MM bus between the FFT core master and the responder
interface fft_resp_if
    import fft_resp_pkg::*;
#(
    parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
    parameter int DATAWIDTH    = DEF_DATAWIDTH
) ();

    logic [ADDRESSWIDTH-1:0] avs_address;
    logic                    avs_write;
    logic [DATAWIDTH-1:0]    avs_writedata;
    logic                    avs_read;
    logic [DATAWIDTH-1:0]    avs_readdata;
    logic                    avs_readdatavalid;
    logic                    avs_waitrequest;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );

endinterface

// File: rtl/fft_resp_rdpipe.sv
// rtl/fft_resp_rdpipe.sv - fixed-latency valid/data shift pipeline for read responses
module fft_resp_rdpipe
    import fft_resp_pkg::*;
#(
    parameter int DW  = DEF_DATAWIDTH,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    logic [LAT-1:0] valid_q;
    logic [DW-1:0]  data_q [LAT];

    // Shift responses one stage per cycle; idle slots carry zero data so readdata rests at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_valid_i ? in_data_i : '0;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LAT-1];
    assign out_data_o  = data_q[LAT-1];

endmodule

// File: rtl/fft_result_responder.sv
// rtl/fft_result_responder.sv - Avalon-MM responder/buffer for FFT results; FFT_RESP_ORDER_CHECK_EN enables write-order checking
module fft_result_responder
    import fft_resp_pkg::*;
#(
    parameter int                      ADDRESSWIDTH   = DEF_ADDRESSWIDTH,
    parameter int                      DATAWIDTH      = DEF_DATAWIDTH,
    parameter int                      IDX_W          = DEF_IDX_W,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR      = '0,
    parameter int                      WAIT_CYCLES    = 3,
    parameter int                      READ_LATENCY   = 2,
    parameter int                      WORDS_EXPECTED = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_resp_if.slave            avs,
    input  logic [IDX_W-1:0]     dbg_index,
    output logic [DATAWIDTH-1:0] dbg_data,
    input  logic                 clear,
    output logic [IDX_W:0]       write_count,
    output logic                 done,
    output logic                 addr_err,
    output logic                 order_err
);

    localparam logic [WCNT_W-1:0] WAIT_L   = WCNT_W'(WAIT_CYCLES);
    localparam logic [IDX_W:0]    CNT_MAX  = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]    WORDS_L  = (IDX_W+1)'(WORDS_EXPECTED);

    resp_state_e        state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               req, accept;

    logic [63:0]        word_idx;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic               unused_idx_bits;

    logic               wr_acc, rd_acc, both_req, wr_store, cnt_inc;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               done_q, done_d, addr_err_q, addr_err_d;
    logic [DATAWIDTH-1:0] dbg_data_q;
    logic [DATAWIDTH-1:0] rd_data;

    logic [DATAWIDTH-1:0] mem [2**IDX_W];

    assign req      = avs.avs_write | avs.avs_read;
    assign word_idx = addr_word_index(64'(avs.avs_address), 64'(BASE_ADDR));
    assign in_range = addr_in_range(64'(avs.avs_address), 64'(BASE_ADDR), IDX_W);
    assign idx      = word_idx[IDX_W-1:0];
    assign unused_idx_bits = ^word_idx[63:IDX_W];

    // Stall FSM: count WAIT_CYCLES of waitrequest, then accept in one cycle if the request held.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        accept = 1'b1;
                    end else begin
                        wcnt_d  = {{(WCNT_W-1){1'b0}}, 1'b1};
                        state_d = (WAIT_L == 4'd1) ? ACCEPT : STALL;
                    end
                end
            end
            STALL: begin
                if (!req) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q + 4'd1 == WAIT_L) state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                accept  = req;
                state_d = IDLE;
                wcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
            wcnt_d  = '0;
        end
    end

    // FSM state and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign avs.avs_waitrequest = req & ~accept;

    // Write wins when both strobes are up; the read is dropped and flagged as an error.
    assign wr_acc   = accept & avs.avs_write;
    assign rd_acc   = accept & avs.avs_read & ~avs.avs_write;
    assign both_req = accept & avs.avs_write & avs.avs_read;
    assign wr_store = wr_acc & in_range;
    assign cnt_inc  = wr_store & (cnt_q != CNT_MAX);

    // Counter and sticky flags; clear overrides any same-cycle update.
    always_comb begin
        cnt_d      = cnt_q + {{IDX_W{1'b0}}, cnt_inc};
        done_d     = done_q | (cnt_inc & (cnt_d == WORDS_L));
        addr_err_d = addr_err_q | (accept & ~in_range) | both_req;
        if (clear) begin
            cnt_d      = '0;
            done_d     = 1'b0;
            addr_err_d = 1'b0;
        end
    end

    // Status and debug-read registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            dbg_data_q <= mem[dbg_index];
        end
    end

    // Result buffer; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_store) mem[idx] <= avs.avs_writedata;
    end

    assign rd_data = in_range ? mem[idx] : '0;

    fft_resp_rdpipe #(
        .DW  (DATAWIDTH),
        .LAT (READ_LATENCY)
    ) u_rdpipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_acc),
        .in_data_i   (rd_data),
        .out_valid_o (avs.avs_readdatavalid),
        .out_data_o  (avs.avs_readdata)
    );

`ifdef FFT_RESP_ORDER_CHECK_EN
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic             order_err_q, order_err_d;

    // Expected index advances on every stored write and wraps with the buffer.
    always_comb begin
        exp_idx_d   = exp_idx_q;
        order_err_d = order_err_q;
        if (wr_store) begin
            exp_idx_d = exp_idx_q + 1'b1;
            if (idx != exp_idx_q) order_err_d = 1'b1;
        end
        if (clear) begin
            exp_idx_d   = '0;
            order_err_d = 1'b0;
        end
    end

    // Order tracker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_idx_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            exp_idx_q   <= exp_idx_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

    assign write_count = cnt_q;
    assign done        = done_q;
    assign addr_err    = addr_err_q;
    assign dbg_data    = dbg_data_q;

endmodule
